// File: rtl/rgfile_param_pkg.sv
// -----------------------------------------------------------------------------
// rgfile_param_pkg
// Shared constants for the parametrised Y86 register file:
//   - default geometry (DATA_W, NREG, ADDR_W)
//   - RNONE, the all-ones "no register" id
//   - Y86 architectural register ids RRAX..RR14
//   - id_valid(): an id names a real register only when it is below NREG
// -----------------------------------------------------------------------------
package rgfile_param_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_NREG   = 15;
    localparam int DEF_ADDR_W = 4;

    localparam logic [DEF_ADDR_W-1:0] RNONE = 4'hF;

    localparam logic [DEF_ADDR_W-1:0] RRAX = 4'h0;
    localparam logic [DEF_ADDR_W-1:0] RRCX = 4'h1;
    localparam logic [DEF_ADDR_W-1:0] RRDX = 4'h2;
    localparam logic [DEF_ADDR_W-1:0] RRBX = 4'h3;
    localparam logic [DEF_ADDR_W-1:0] RRSP = 4'h4;
    localparam logic [DEF_ADDR_W-1:0] RRBP = 4'h5;
    localparam logic [DEF_ADDR_W-1:0] RRSI = 4'h6;
    localparam logic [DEF_ADDR_W-1:0] RRDI = 4'h7;
    localparam logic [DEF_ADDR_W-1:0] RR8  = 4'h8;
    localparam logic [DEF_ADDR_W-1:0] RR9  = 4'h9;
    localparam logic [DEF_ADDR_W-1:0] RR10 = 4'hA;
    localparam logic [DEF_ADDR_W-1:0] RR11 = 4'hB;
    localparam logic [DEF_ADDR_W-1:0] RR12 = 4'hC;
    localparam logic [DEF_ADDR_W-1:0] RR13 = 4'hD;
    localparam logic [DEF_ADDR_W-1:0] RR14 = 4'hE;

    // Ids at or above the register count (including RNONE) are "none".
    function automatic logic id_valid(input logic [31:0] id, input logic [31:0] nreg);
        return id < nreg;
    endfunction

endpackage

// File: rtl/rgfile_param_if.sv
// -----------------------------------------------------------------------------
// rgfile_param_if
// Bundle between the W/D pipeline stages and the register file.
//   master (pipeline side): drives writeback ids/data, read ids, reservations;
//                           receives read data, busy flags, sb_err_o, regs_o.
//   slave  (register file): the mirror image.
// -----------------------------------------------------------------------------
interface rgfile_param_if
    import rgfile_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0]      W_dstE_i;
    logic [DATA_W-1:0]      W_valE_i;
    logic [ADDR_W-1:0]      W_dstM_i;
    logic [DATA_W-1:0]      W_valM_i;
    logic [ADDR_W-1:0]      d_srcA_i;
    logic [ADDR_W-1:0]      d_srcB_i;
    logic [ADDR_W-1:0]      d_resvE_i;
    logic [ADDR_W-1:0]      d_resvM_i;
    logic [DATA_W-1:0]      d_rvalA_o;
    logic [DATA_W-1:0]      d_rvalB_o;
    logic                   d_busyA_o;
    logic                   d_busyB_o;
    logic                   sb_err_o;
    logic [NREG*DATA_W-1:0] regs_o;

    modport master (
        output W_dstE_i, W_valE_i, W_dstM_i, W_valM_i,
        output d_srcA_i, d_srcB_i, d_resvE_i, d_resvM_i,
        input  d_rvalA_o, d_rvalB_o, d_busyA_o, d_busyB_o, sb_err_o, regs_o
    );

    modport slave (
        input  W_dstE_i, W_valE_i, W_dstM_i, W_valM_i,
        input  d_srcA_i, d_srcB_i, d_resvE_i, d_resvM_i,
        output d_rvalA_o, d_rvalB_o, d_busyA_o, d_busyB_o, sb_err_o, regs_o
    );

endinterface

// File: rtl/rgfile_param_sbcnt.sv
// -----------------------------------------------------------------------------
// rgfile_sbcnt
// One pending-write counter of the scoreboard. Saturating up/down counter:
// up to two increments and two decrements may arrive on the same edge.
//   clk, rst   : clock, asynchronous active-low reset
//   inc0, inc1 : reservation requests (each +1)
//   dec0, dec1 : writebacks (each -1)
//   cnt        : current count
//   ovf        : high when this edge's result leaves 0..2^CNT_W-1
//                (over- or underflow); the count saturates instead
// -----------------------------------------------------------------------------
module rgfile_sbcnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc0,
    input  logic             inc1,
    input  logic             dec0,
    input  logic             dec1,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    // Two guard bits: the sum can reach 2^CNT_W+1 before saturation.
    localparam int EXT_W = CNT_W + 2;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [EXT_W-1:0] up_sum;
    logic [EXT_W-1:0] dn_sum;
    logic [EXT_W-1:0] diff;

    always_comb begin
        up_sum   = {2'b00, cnt_reg} + EXT_W'(inc0) + EXT_W'(inc1);
        dn_sum   = EXT_W'(dec0) + EXT_W'(dec1);
        diff     = up_sum - dn_sum;
        cnt_next = diff[CNT_W-1:0];
        ovf      = 1'b0;
        if (up_sum < dn_sum) begin
            cnt_next = '0;
            ovf      = 1'b1;
        end else if (diff > MAX_EXT) begin
            cnt_next = MAX_EXT[CNT_W-1:0];
            ovf      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/rgfile_param.sv
// -----------------------------------------------------------------------------
// rgfile_param
// Parametrised Y86 register file between the W and D stages.
//   clk  : clock, rising-edge updates
//   rst  : asynchronous active-low reset; all state and outputs read 0 while low
//   bus  : rgfile_param_if.slave
//          W_dstE/valE, W_dstM/valM : two writeback ports (M wins on same id)
//          d_srcA/B -> d_rvalA/B    : combinational read ports, optional bypass
//          d_resvE/M                : pending-write reservations (scoreboard +1)
//          d_busyA/B                : src still has an unsatisfied pending write
//          sb_err_o                 : sticky scoreboard over/underflow
//          regs_o                   : flat debug view, reg i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module rgfile_param
    import rgfile_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 2
) (
    input  logic           clk,
    input  logic           rst,
    rgfile_param_if.slave  bus
);
    logic [ADDR_W-1:0]      w_dst_e;
    logic [ADDR_W-1:0]      w_dst_m;
    logic [DATA_W-1:0]      w_val_e;
    logic [DATA_W-1:0]      w_val_m;

    logic [NREG-1:0]        hit_e;
    logic [NREG-1:0]        hit_m;
    logic [NREG-1:0]        resv_e;
    logic [NREG-1:0]        resv_m;
    logic [NREG-1:0]        ovf;

    logic [DATA_W-1:0]      regs_reg [NREG];
    logic [CNT_W-1:0]       cnt      [NREG];
    logic                   sb_err_reg;
    logic [NREG*DATA_W-1:0] regs_flat;

    assign w_dst_e = bus.W_dstE_i;
    assign w_dst_m = bus.W_dstM_i;
    assign w_val_e = bus.W_valE_i;
    assign w_val_m = bus.W_valM_i;

    // Per-register decode, storage and scoreboard counter. An id only matches
    // a generated index below NREG, so "none" ids never hit anything.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] ID = ADDR_W'(gi);

            assign hit_e[gi]  = (w_dst_e == ID);
            assign hit_m[gi]  = (w_dst_m == ID);
            assign resv_e[gi] = (bus.d_resvE_i == ID);
            assign resv_m[gi] = (bus.d_resvM_i == ID);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs_reg[gi] <= '0;
                end else if (hit_m[gi]) begin
                    regs_reg[gi] <= w_val_m;
                end else if (hit_e[gi]) begin
                    regs_reg[gi] <= w_val_e;
                end
            end

            rgfile_sbcnt #(
                .CNT_W (CNT_W)
            ) u_sbcnt (
                .clk  (clk),
                .rst  (rst),
                .inc0 (resv_e[gi]),
                .inc1 (resv_m[gi]),
                .dec0 (hit_e[gi]),
                .dec1 (hit_m[gi]),
                .cnt  (cnt[gi]),
                .ovf  (ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_err_reg <= 1'b0;
        end else if (|ovf) begin
            sb_err_reg <= 1'b1;
        end
    end

    // Read port: M beats E beats stored state when forwarding is enabled.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] src);
        logic [DATA_W-1:0] v;
        v = '0;
        if (id_valid(32'(src), 32'(NREG))) begin
            if ((BYPASS != 0) && (w_dst_m == src)) begin
                v = w_val_m;
            end else if ((BYPASS != 0) && (w_dst_e == src)) begin
                v = w_val_e;
            end else begin
                v = regs_reg[src];
            end
        end
        return v;
    endfunction

    // With forwarding, writebacks landing this cycle already satisfy their
    // share of the pending count, so they are subtracted before the test.
    function automatic logic busy_of(input logic [ADDR_W-1:0] src);
        logic [CNT_W:0] pend;
        logic [CNT_W:0] wb;
        logic           b;
        b = 1'b0;
        if (id_valid(32'(src), 32'(NREG))) begin
            pend = {1'b0, cnt[src]};
            wb   = (CNT_W+1)'(w_dst_e == src) + (CNT_W+1)'(w_dst_m == src);
            if (BYPASS != 0) begin
                b = (pend > wb);
            end else begin
                b = (pend != '0);
            end
        end
        return b;
    endfunction

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_reg[i];
        end
    end

    // Forwarded W data would otherwise leak through during reset.
    always_comb begin
        bus.d_rvalA_o = '0;
        bus.d_rvalB_o = '0;
        bus.d_busyA_o = 1'b0;
        bus.d_busyB_o = 1'b0;
        if (rst) begin
            bus.d_rvalA_o = read_val(bus.d_srcA_i);
            bus.d_rvalB_o = read_val(bus.d_srcB_i);
            bus.d_busyA_o = busy_of(bus.d_srcA_i);
            bus.d_busyB_o = busy_of(bus.d_srcB_i);
        end
    end

    assign bus.sb_err_o = sb_err_reg;
    assign bus.regs_o   = regs_flat;

endmodule

// File: tb/tb_rgfile_param.sv
// -----------------------------------------------------------------------------
// tb_rgfile_param
// Table of write/read vectors plus hand-built sequences for the scoreboard,
// saturation and asynchronous reset. Expectations are queued when stimulus is
// driven and popped/compared once the outputs have settled.
// -----------------------------------------------------------------------------
module tb_rgfile_param;

    localparam int DW = 64;
    localparam int NR = 15;
    localparam int AW = 4;

    localparam int SEL_RVALA = 0;
    localparam int SEL_RVALB = 1;
    localparam int SEL_BUSYA = 2;
    localparam int SEL_BUSYB = 3;
    localparam int SEL_ERR   = 4;
    localparam int SEL_REG   = 5;

    logic clk;
    logic rst;

    rgfile_param_if #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW)) bus ();

    rgfile_param #(
        .DATA_W (DW),
        .NREG   (NR),
        .ADDR_W (AW),
        .BYPASS (1),
        .CNT_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [63:0] exp;
    } chk_t;

    typedef struct {
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [63:0] ea;
        logic [63:0] eb;
    } vec_t;

    chk_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] mdl [NR];

    function automatic logic [63:0] actual(input int sel, input int idx);
        logic [63:0] a;
        case (sel)
            SEL_RVALA: a = bus.d_rvalA_o;
            SEL_RVALB: a = bus.d_rvalB_o;
            SEL_BUSYA: a = 64'(bus.d_busyA_o);
            SEL_BUSYB: a = 64'(bus.d_busyB_o);
            SEL_ERR:   a = 64'(bus.sb_err_o);
            default:   a = bus.regs_o[idx*DW +: DW];
        endcase
        return a;
    endfunction

    task automatic expect_val(input string name, input int sel, input int idx, input logic [63:0] e);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.idx  = idx;
        c.exp  = e;
        exp_q.push_back(c);
    endtask

    task automatic drain();
        chk_t        c;
        logic [63:0] a;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            a = actual(c.sel, c.idx);
            total++;
            if (a !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", c.name, a, c.exp);
            end else begin
                $display("ok   %s: %h", c.name, a);
            end
        end
    endtask

    task automatic drive(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] re, input logic [3:0] rm);
        bus.W_dstE_i  = de;
        bus.W_valE_i  = ve;
        bus.W_dstM_i  = dm;
        bus.W_valM_i  = vm;
        bus.d_srcA_i  = sa;
        bus.d_srcB_i  = sb;
        bus.d_resvE_i = re;
        bus.d_resvM_i = rm;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check();
        #3;
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    vec_t vt [8];

    initial begin
        vt[0] = '{4'h0, 64'h13, 4'hF, 64'h0,    4'h0, 4'h1, 64'h13,   64'h0};
        vt[1] = '{4'hF, 64'h0,  4'hF, 64'h0,    4'h0, 4'hF, 64'h13,   64'h0};
        vt[2] = '{4'h4, 64'hAA, 4'h4, 64'hBB,   4'h4, 4'h4, 64'hBB,   64'hBB};
        vt[3] = '{4'hF, 64'h55, 4'hF, 64'h66,   4'hF, 4'h4, 64'h0,    64'hBB};
        vt[4] = '{4'h7, 64'h77, 4'h8, 64'h88,   4'h8, 4'h7, 64'h88,   64'h77};
        vt[5] = '{4'hE, 64'hEE, 4'hF, 64'h0,    4'h7, 4'hE, 64'h77,   64'hEE};
        vt[6] = '{4'hF, 64'h99, 4'h0, 64'h1234, 4'h0, 4'h0, 64'h1234, 64'h1234};
        vt[7] = '{4'h0, 64'h5,  4'hF, 64'h0,    4'h0, 4'h4, 64'h5,    64'hBB};
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        // Reset: outputs forced to 0 even with live W traffic.
        rst = 1'b1;
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        #1;
        rst = 1'b0;
        drive(4'h0, 64'h13, 4'hF, 64'h0, 4'h0, 4'hF, 4'hF, 4'hF);
        expect_val("rst_rvalA", SEL_RVALA, 0, 64'h0);
        expect_val("rst_busyA", SEL_BUSYA, 0, 64'h0);
        expect_val("rst_err",   SEL_ERR,   0, 64'h0);
        expect_val("rst_r0",    SEL_REG,   0, 64'h0);
        #2;
        drain();
        tick();
        rst = 1'b1;

        // Table: same-cycle forwarded reads, then stored-state model compare.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].de, vt[i].ve, vt[i].dm, vt[i].vm, vt[i].sa, vt[i].sb, 4'hF, 4'hF);
            expect_val($sformatf("vec%0d_rvalA", i), SEL_RVALA, 0, vt[i].ea);
            expect_val($sformatf("vec%0d_rvalB", i), SEL_RVALB, 0, vt[i].eb);
            settle_check();
            if (vt[i].de < 4'(NR)) mdl[vt[i].de] = vt[i].ve;
            if (vt[i].dm < 4'(NR)) mdl[vt[i].dm] = vt[i].vm;
            tick();
        end
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h0, 4'hF, 4'hF);
        for (int i = 0; i < NR; i++) begin
            expect_val($sformatf("table_r%0d", i), SEL_REG, i, mdl[i]);
        end
        expect_val("stored_rvalA_r4", SEL_RVALA, 0, 64'hBB);
        expect_val("stored_rvalB_r0", SEL_RVALB, 0, 64'h5);
        settle_check();

        // Pending writes on id 2: two reservations, two writebacks.
        do_reset();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'h2, 4'hF, 4'h2, 4'hF);
        expect_val("resv1_busyA", SEL_BUSYA, 0, 64'h0);
        settle_check();
        tick();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'h2, 4'hF, 4'h2, 4'hF);
        expect_val("resv2_busyA", SEL_BUSYA, 0, 64'h1);
        settle_check();
        tick();
        drive(4'h2, 64'h22, 4'hF, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF);
        expect_val("wb1_busyA", SEL_BUSYA, 0, 64'h1);
        expect_val("wb1_rvalA", SEL_RVALA, 0, 64'h22);
        settle_check();
        tick();
        drive(4'h2, 64'h23, 4'hF, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF);
        expect_val("wb2_busyA", SEL_BUSYA, 0, 64'h0);
        expect_val("wb2_rvalA", SEL_RVALA, 0, 64'h23);
        settle_check();
        tick();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF);
        expect_val("idle_busyA", SEL_BUSYA, 0, 64'h0);
        expect_val("idle_rvalA", SEL_RVALA, 0, 64'h23);
        expect_val("balanced_err", SEL_ERR, 0, 64'h0);
        settle_check();

        // Saturation: four reservations on id 3 hold the count at 3.
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'h3, 4'h3, 4'h3);
        expect_val("sat1_busyB", SEL_BUSYB, 0, 64'h0);
        settle_check();
        tick();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'h3, 4'h3, 4'h3);
        expect_val("sat2_busyB", SEL_BUSYB, 0, 64'h1);
        expect_val("sat2_err",   SEL_ERR,   0, 64'h0);
        settle_check();
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'h3, 64'h31 + 64'(k), 4'hF, 64'h0, 4'hF, 4'h3, 4'hF, 4'hF);
            expect_val($sformatf("satwb%0d_busyB", k), SEL_BUSYB, 0, (k < 2) ? 64'h1 : 64'h0);
            expect_val($sformatf("satwb%0d_err", k),   SEL_ERR,   0, 64'h1);
            settle_check();
            tick();
        end
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'h3, 4'hF, 4'hF);
        expect_val("sat_end_busyB", SEL_BUSYB, 0, 64'h0);
        expect_val("sat_r2",        SEL_REG,   2, 64'h23);
        expect_val("sat_r3",        SEL_REG,   3, 64'h33);
        expect_val("sat_r5",        SEL_REG,   5, 64'h0);
        settle_check();

        // Underflow: writeback to an idle id.
        do_reset();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        expect_val("clean_err", SEL_ERR, 0, 64'h0);
        settle_check();
        drive(4'h5, 64'h5, 4'hF, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF, 4'h9, 4'hF);
        expect_val("under_err", SEL_ERR, 0, 64'h1);
        expect_val("under_r5",  SEL_REG, 5, 64'h5);
        settle_check();
        tick();

        // Asynchronous reset mid-cycle with a write in flight.
        drive(4'h3, 64'h77, 4'hF, 64'h0, 4'h3, 4'h9, 4'hF, 4'hF);
        expect_val("pre_rst_rvalA", SEL_RVALA, 0, 64'h77);
        expect_val("pre_rst_busyB", SEL_BUSYB, 0, 64'h1);
        settle_check();
        rst = 1'b0;
        #1;
        expect_val("arst_rvalA", SEL_RVALA, 0, 64'h0);
        expect_val("arst_busyB", SEL_BUSYB, 0, 64'h0);
        expect_val("arst_err",   SEL_ERR,   0, 64'h0);
        expect_val("arst_r5",    SEL_REG,   5, 64'h0);
        drain();
        tick();
        rst = 1'b1;
        drive(4'h1, 64'h1111, 4'hF, 64'h0, 4'h3, 4'h9, 4'hF, 4'hF);
        expect_val("post_rst_rvalA", SEL_RVALA, 0, 64'h0);
        settle_check();
        tick();
        drive(4'hF, 64'h0, 4'hF, 64'h0, 4'h1, 4'h9, 4'hF, 4'hF);
        expect_val("post_rvalA_r1", SEL_RVALA, 0, 64'h1111);
        expect_val("post_busyB",    SEL_BUSYB, 0, 64'h0);
        for (int i = 0; i < NR; i++) begin
            expect_val($sformatf("post_r%0d", i), SEL_REG, i, (i == 1) ? 64'h1111 : 64'h0);
        end
        settle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
